// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared UART types and constants (transmitter/receiver)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Both ends of the link take this default so their bit periods match.
  localparam int DEFAULT_CLKS_PER_BIT = 1736;

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_baud_counter : modulo-CLKS_PER_BIT bit timer, cleared when    |
// | en is low; bit_done pulses on the last cycle of each bit. Rev 1.0  |
// +--------------------------------------------------------------------+
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!en) begin
      count_d = '0;
    end else if (count_q == LAST_COUNT) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_done = en && (count_q == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_transmitter : valid/ready byte in, start + data (LSB first) + |
// | stop bits out on a registered tx line. Rev 1.0                     |
// +--------------------------------------------------------------------+
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS) + 1;
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
      $error("uart_transmitter: illegal CLKS_PER_BIT, DATA_BITS or STOP_BITS");
    end
  endgenerate

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 bit_done;

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q != IDLE),
    .bit_done (bit_done)
  );

  // tx/ready/busy are computed from the next state so they change on the
  // same edge as the state register.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        bit_idx_d = '0;
        if (valid) begin
          state_d = START;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_DATA_IDX) begin
            state_d   = STOP;
            tx_d      = 1'b1;
            bit_idx_d = '0;
          end else begin
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        // bit_idx is reused to count stop bits.
        if (bit_done) begin
          if (bit_idx_q == LAST_STOP_IDX) begin
            state_d   = IDLE;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_transmitter : scoreboard bench for uart_transmitter        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_transmitter;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic [1:0] sel;

  logic valid_a, valid_b, valid_c;
  logic ready_a, ready_b, ready_c;
  logic tx_a, tx_b, tx_c;
  logic busy_a, busy_b, busy_c;
  logic tx_sel, rdy_sel, busy_sel;

  int n_cmp;
  int n_err;
  int mon_frames;
  int mon_cpb, mon_bits, mon_stop;
  logic [7:0] sb_q[$];

  assign valid_a = valid && (sel == 2'd0);
  assign valid_b = valid && (sel == 2'd1);
  assign valid_c = valid && (sel == 2'd2);

  uart_transmitter #(.CLKS_PER_BIT(16), .DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst_n), .data(data), .valid(valid_a),
    .ready(ready_a), .tx(tx_a), .busy(busy_a));

  uart_transmitter u_dut_b (
    .clk(clk), .rst(rst_n), .data(data), .valid(valid_b),
    .ready(ready_b), .tx(tx_b), .busy(busy_b));

  uart_transmitter #(.CLKS_PER_BIT(16), .DATA_BITS(7), .STOP_BITS(2)) u_dut_c (
    .clk(clk), .rst(rst_n), .data(data[6:0]), .valid(valid_c),
    .ready(ready_c), .tx(tx_c), .busy(busy_c));

  always_comb begin
    tx_sel   = tx_a;
    rdy_sel  = ready_a;
    busy_sel = busy_a;
    if (sel == 2'd1) begin
      tx_sel = tx_b; rdy_sel = ready_b; busy_sel = busy_b;
    end else if (sel == 2'd2) begin
      tx_sel = tx_c; rdy_sel = ready_c; busy_sel = busy_c;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on the first negedge after an accept; walks the whole frame
  // plus the following idle cycle, checking tx, ready and busy each cycle.
  task automatic frame_wave(input string tag, input logic [7:0] b, input int nbits,
                            input int nstop, input int cpb);
    int   errs;
    int   total;
    logic exp_tx, exp_rdy;
    errs  = 0;
    total = (1 + nbits + nstop) * cpb;
    for (int k = 0; k <= total; k++) begin
      if (k < cpb) exp_tx = 1'b0;
      else if (k < (1 + nbits) * cpb) exp_tx = b[k / cpb - 1];
      else exp_tx = 1'b1;
      exp_rdy = (k == total);
      if (tx_sel !== exp_tx || rdy_sel !== exp_rdy || busy_sel !== !exp_rdy) errs++;
      if (k < total) @(negedge clk);
    end
    check(tag, errs, 0);
  endtask

  task automatic mon_wait(input int n, inout bit ab);
    for (int j = 0; j < n && !ab; j++) begin
      @(negedge clk);
      if (!rst_n) ab = 1'b1;
    end
  endtask

  // Serial receiver model: samples mid-bit, then compares against the scoreboard.
  initial begin
    bit         ab;
    logic [7:0] got;
    int         ferr;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst_n && tx_sel === 1'b0) begin
        ab   = 1'b0;
        got  = '0;
        ferr = 0;
        mon_wait(mon_cpb / 2, ab);
        if (!ab && tx_sel !== 1'b0) ferr++;
        for (int i = 0; i < mon_bits; i++) begin
          mon_wait(mon_cpb, ab);
          got[i] = tx_sel;
        end
        for (int s = 0; s < mon_stop; s++) begin
          mon_wait(mon_cpb, ab);
          if (!ab && tx_sel !== 1'b1) ferr++;
        end
        if (ab) begin
          if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
          check("mon_framing", ferr, 0);
          if (sb_q.size() == 0) begin
            check("sb_unexpected_frame", got, 8'hxx);
          end else begin
            exp_b = sb_q.pop_front();
            check("sb_data", got, exp_b);
          end
          mon_frames++;
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0; mon_frames = 0;
    mon_cpb = 16; mon_bits = 8; mon_stop = 1;
    sel = 2'd0; rst_n = 1'b0; data = 8'h00; valid = 1'b1;

    // Reset held with valid high: idle outputs, nothing accepted.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_tx", tx_a, 1'b1);
      check("rst_ready", ready_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", ready_a, 1'b1);
    check("post_rst_tx", tx_a, 1'b1);

    // Single byte with a one-cycle valid pulse.
    data = 8'h48; valid = 1'b1; sb_q.push_back(8'h48);
    @(negedge clk);
    valid = 1'b0;
    frame_wave("t2_frame", 8'h48, 8, 1, 16);

    // Back-to-back with valid held: one idle cycle, 161-cycle period.
    data = 8'h48; valid = 1'b1; sb_q.push_back(8'h48);
    @(negedge clk);
    data = 8'h49;
    frame_wave("t3_frame1", 8'h48, 8, 1, 16);
    @(negedge clk);
    sb_q.push_back(8'h49); valid = 1'b0;
    frame_wave("t3_frame2", 8'h49, 8, 1, 16);

    // Data changed while busy is ignored until the next idle cycle.
    data = 8'h48; valid = 1'b1; sb_q.push_back(8'h48);
    @(negedge clk);
    data = 8'hFF;
    frame_wave("t4_frame1", 8'h48, 8, 1, 16);
    @(negedge clk);
    sb_q.push_back(8'hFF); valid = 1'b0;
    frame_wave("t4_frame2", 8'hFF, 8, 1, 16);

    // Reset during data bit 3 aborts the frame at once.
    data = 8'h48; valid = 1'b1; sb_q.push_back(8'h48);
    @(negedge clk);
    valid = 1'b0;
    repeat (70) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_abort_tx", tx_a, 1'b1);
    check("t5_abort_ready", ready_a, 1'b1);
    check("t5_abort_busy", busy_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    data = 8'h55; valid = 1'b1; sb_q.push_back(8'h55);
    @(negedge clk);
    valid = 1'b0;
    frame_wave("t5_frame", 8'h55, 8, 1, 16);

    // Seven data bits, two stop bits, valid held for two frames.
    sel = 2'd2; mon_bits = 7; mon_stop = 2; mon_cpb = 16;
    @(negedge clk);
    data = 8'h41; valid = 1'b1; sb_q.push_back(8'h41);
    @(negedge clk);
    frame_wave("t7_frame1", 8'h41, 7, 2, 16);
    @(negedge clk);
    sb_q.push_back(8'h41); valid = 1'b0;
    frame_wave("t7_frame2", 8'h41, 7, 2, 16);

    // Default bit period, two frames back to back through the receiver model.
    sel = 2'd1; mon_bits = 8; mon_stop = 1; mon_cpb = 1736;
    @(negedge clk);
    data = 8'h48; valid = 1'b1; sb_q.push_back(8'h48);
    @(negedge clk);
    data = 8'h49;
    frame_wave("t6_frame1", 8'h48, 8, 1, 1736);
    @(negedge clk);
    sb_q.push_back(8'h49); valid = 1'b0;
    frame_wave("t6_frame2", 8'h49, 8, 1, 1736);

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    check("mon_frames", mon_frames, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
